// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_pkg
// Description : Shared types and constants for the RTC bus sequencer/arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_bus_pkg;

  // Bus sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_SET = 3'd1,
    ADDR_STB = 3'd2,
    ADDR_HLD = 3'd3,
    DATA_STB = 3'd4,
    RECOV    = 3'd5
  } state_e;

  // Transaction direction
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Requester port indices, also the encoding of the last-grant register
  localparam logic PORT_WR = 1'b0;
  localparam logic PORT_RD = 1'b1;

  // Command byte the refresh FSM issues ahead of time/timer reads
  localparam logic [7:0] RTC_CMD_XFER = 8'hF0;

  // Pin-level strobe bundle; ad/cs/rd/wr are active-low
  typedef struct packed {
    logic ad;
    logic cs;
    logic rd;
    logic wr;
    logic dir;
  } strobes_t;

  // Strobe levels a given state presents on the RTC pins
  function automatic strobes_t phase_strobes(state_e st, op_e op);
    strobes_t s;
    s = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, dir: 1'b0};
    case (st)
      ADDR_SET: s.ad = 1'b0;
      ADDR_STB: begin
        s.ad = 1'b0;
        s.cs = 1'b0;
        s.wr = 1'b0;
      end
      DATA_STB: begin
        s.cs = 1'b0;
        if (op == OP_RD) begin
          s.rd  = 1'b0;
          s.dir = 1'b1;
        end else begin
          s.wr  = 1'b0;
        end
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage : rtc_bus_pkg
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_phase_timer
// Description : Loadable down-counter timing one bus phase; done while zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load on phase entry, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule : rtc_phase_timer
`default_nettype wire

// File: rtl/rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_arbiter
// Description : Round-robin writer/reader arbiter and timed address/data
//               transaction engine for the multiplexed RTC bus.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       busy,
  input  logic [7:0] Dato,
  output logic [7:0] Dato_out,
  output logic       Dir_Dat,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR
);

  localparam int CNT_W = $clog2(2 * PHASE_CYC);
  localparam logic [CNT_W-1:0] LOAD_PH = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_DS = CNT_W'(2 * PHASE_CYC - 1);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       wr_ack_q, wr_ack_d;
  logic       rd_ack_q, rd_ack_d;
  logic       busy_q, busy_d;
  logic [7:0] dato_out_q, dato_out_d;
  strobes_t   stb_q, stb_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             grant_rd;

  // A port is still high during its own ack cycle; it must not win again then
  logic wr_pend;
  logic rd_pend;
  assign wr_pend = wr_req & ~wr_ack_q;
  assign rd_pend = rd_req & ~rd_ack_q;

  rtc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state, arbitration, and next-value decode of every registered pin
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    cap_d     = cap_q;
    rd_data_d = rd_data_q;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = LOAD_PH;
    grant_rd  = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_pend || rd_pend) begin
          grant_rd = (wr_pend && rd_pend) ? (last_q == PORT_WR) : rd_pend;
          op_d     = grant_rd ? OP_RD : OP_WR;
          addr_d   = grant_rd ? rd_addr : wr_addr;
          data_d   = wr_data;
          last_d   = grant_rd ? PORT_RD : PORT_WR;
          state_d  = ADDR_SET;
          tmr_load = 1'b1;
        end
      end
      ADDR_SET: begin
        if (tmr_done) begin
          state_d  = ADDR_STB;
          tmr_load = 1'b1;
        end
      end
      ADDR_STB: begin
        if (tmr_done) begin
          state_d  = ADDR_HLD;
          tmr_load = 1'b1;
        end
      end
      ADDR_HLD: begin
        if (tmr_done) begin
          state_d  = DATA_STB;
          tmr_load = 1'b1;
          tmr_val  = LOAD_DS;
        end
      end
      DATA_STB: begin
        if (tmr_done) begin
          if (op_q == OP_RD) begin
            cap_d = Dato;
          end
          state_d  = RECOV;
          tmr_load = 1'b1;
        end
      end
      RECOV: begin
        if (tmr_done) begin
          state_d = IDLE;
          if (op_q == OP_RD) begin
            rd_ack_d  = 1'b1;
            rd_data_d = cap_q;
          end else begin
            wr_ack_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    stb_d  = phase_strobes(state_d, op_d);
    busy_d = (state_d != IDLE);
    case (state_d)
      ADDR_SET, ADDR_STB, ADDR_HLD: dato_out_d = addr_d;
      DATA_STB: dato_out_d = (op_d == OP_WR) ? data_d : 8'h00;
      default:  dato_out_d = 8'h00;
    endcase
  end

  // FSM state, latched transaction and registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      last_q     <= PORT_RD;
      cap_q      <= 8'h00;
      rd_data_q  <= 8'h00;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      dato_out_q <= 8'h00;
      stb_q      <= '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, dir: 1'b0};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      busy_q     <= busy_d;
      dato_out_q <= dato_out_d;
      stb_q      <= stb_d;
    end
  end

  assign wr_ack   = wr_ack_q;
  assign rd_ack   = rd_ack_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign Dato_out = dato_out_q;
  assign Dir_Dat  = stb_q.dir;
  assign AD       = stb_q.ad;
  assign CS       = stb_q.cs;
  assign RD       = stb_q.rd;
  assign WR       = stb_q.wr;

endmodule : rtc_bus_arbiter
`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_arbiter
// Description : Self-checking bench for rtc_bus_arbiter: transaction-level
//               reference model plus directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_arbiter;

  localparam int P = 2;

  logic       clk;
  logic       rst;
  logic       wr_req, rd_req;
  logic [7:0] wr_addr, wr_data, rd_addr, Dato;
  logic       wr_ack, rd_ack, busy, Dir_Dat, AD, CS, RD, WR;
  logic [7:0] rd_data, Dato_out;

  int total = 0;
  int bad   = 0;

  rtc_bus_arbiter #(.PHASE_CYC(P)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .busy(busy), .Dato(Dato), .Dato_out(Dato_out), .Dir_Dat(Dir_Dat),
    .AD(AD), .CS(CS), .RD(RD), .WR(WR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_k counts cycles since the grant: 1..P addr setup, P+1..2P addr strobe,
  // 2P+1..3P addr hold, 3P+1..5P data strobe, 5P+1..6P recovery.
  bit       m_busy = 0, m_op_rd = 0, m_last_rd = 1, m_wack = 0, m_rack = 0;
  int       m_k = 0;
  bit [7:0] m_addr = 0, m_data = 0, m_rdata = 0, m_cap = 0;
  bit       e_ad, e_cs, e_rd, e_wr, e_dir, wr_e, rd_e, g_rd;
  bit [7:0] e_do;

  always @(negedge clk) begin
    e_ad = 1; e_cs = 1; e_rd = 1; e_wr = 1; e_dir = 0; e_do = 8'h00;
    if (m_busy) begin
      if (m_k <= P) begin
        e_ad = 0; e_do = m_addr;
      end else if (m_k <= 2*P) begin
        e_ad = 0; e_cs = 0; e_wr = 0; e_do = m_addr;
      end else if (m_k <= 3*P) begin
        e_do = m_addr;
      end else if (m_k <= 5*P) begin
        e_cs = 0;
        if (m_op_rd) begin e_rd = 0; e_dir = 1; end
        else begin e_wr = 0; e_do = m_data; end
      end
    end
    chk("model_pins",
        {8'h00, AD, CS, RD, WR, Dir_Dat, busy, wr_ack, rd_ack, Dato_out, rd_data},
        {8'h00, e_ad, e_cs, e_rd, e_wr, e_dir, m_busy, m_wack, m_rack, e_do, m_rdata});

    // advance the model with this cycle's inputs
    if (rst) begin
      m_busy = 0; m_wack = 0; m_rack = 0; m_rdata = 0; m_last_rd = 1;
    end else if (!m_busy) begin
      wr_e = wr_req && !m_wack;
      rd_e = rd_req && !m_rack;
      m_wack = 0; m_rack = 0;
      g_rd = (wr_e && rd_e) ? !m_last_rd : rd_e;
      if (wr_e || rd_e) begin
        m_busy = 1; m_k = 1; m_op_rd = g_rd; m_last_rd = g_rd;
        m_addr = g_rd ? rd_addr : wr_addr;
        m_data = wr_data;
      end
    end else begin
      if (m_k == 5*P && m_op_rd) m_cap = Dato;
      if (m_k == 6*P) begin
        m_busy = 0;
        if (m_op_rd) begin m_rack = 1; m_rdata = m_cap; end
        else m_wack = 1;
      end else begin
        m_k++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus and directed checks ----------------
  int  order[4];
  int  n_ack, nw, nr;
  bit  wr_rr, rd_rr, dir_ever, got;

  initial begin
    rst = 1; wr_req = 0; rd_req = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; Dato = 0;
    repeat (3) @(posedge clk);
    #1 chk("reset_pins", {24'h0, AD, CS, RD, WR, Dir_Dat, busy, wr_ack, rd_ack}, {24'h0, 8'b1111_0000});
    chk("reset_rd_data", {24'h0, rd_data}, 32'h0);
    #1 rst = 0;

    // directed read, addr 21, Dato 45
    @(posedge clk); #2 rd_req = 1; rd_addr = 8'h21; Dato = 8'h45;
    for (int r = 1; r <= 14; r++) begin
      @(posedge clk); #1;
      case (r)
        1:  begin chk("rd_ad_c1", {31'h0, AD}, 0); chk("rd_addr_c1", {24'h0, Dato_out}, 32'h21); end
        2:  chk("rd_cs_c2", {31'h0, CS}, 1);
        3:  chk("rd_cswr_c3", {30'h0, CS, WR}, 0);
        4:  chk("rd_adcswr_c4", {29'h0, AD, CS, WR}, 0);
        5:  chk("rd_ad_c5", {31'h0, AD}, 1);
        6:  chk("rd_rd_c6", {30'h0, RD, Dir_Dat}, 2'b10);
        7:  chk("rd_rddir_c7", {30'h0, RD, Dir_Dat}, 2'b01);
        10: chk("rd_rddir_c10", {30'h0, RD, Dir_Dat}, 2'b01);
        11: chk("rd_rddir_c11", {30'h0, RD, Dir_Dat}, 2'b10);
        12: begin chk("rd_ack_c12", {31'h0, rd_ack}, 0); chk("rd_data_c12", {24'h0, rd_data}, 0); end
        13: begin chk("rd_ack_c13", {31'h0, rd_ack}, 1); chk("rd_data_c13", {24'h0, rd_data}, 32'h45); end
        14: chk("rd_ack_c14", {31'h0, rd_ack}, 0);
        default: ;
      endcase
      #1 if (rd_ack) rd_req = 0;
    end

    // directed write, addr 42 data 30
    dir_ever = 0;
    @(posedge clk); #2 wr_req = 1; wr_addr = 8'h42; wr_data = 8'h30;
    for (int r = 1; r <= 14; r++) begin
      @(posedge clk); #1;
      dir_ever |= Dir_Dat;
      if (r <= 6) chk("wr_addr_out", {24'h0, Dato_out}, 32'h42);
      else if (r <= 10) chk("wr_data_out", {23'h0, WR, Dato_out}, {23'h0, 1'b0, 8'h30});
      if (r == 12) chk("wr_ack_c12", {31'h0, wr_ack}, 0);
      if (r == 13) chk("wr_ack_c13", {31'h0, wr_ack}, 1);
      #1 if (wr_ack) wr_req = 0;
    end
    chk("wr_dir_never", {31'h0, dir_ever}, 0);

    // both requesters from reset: W R W R
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0; wr_req = 1; rd_req = 1; wr_addr = 8'h10; rd_addr = 8'h20; Dato = 8'h3C;
    n_ack = 0; wr_rr = 0; rd_rr = 0;
    for (int c = 0; c < 200 && n_ack < 4; c++) begin
      @(posedge clk); #1;
      if (wr_ack && n_ack < 4) order[n_ack++] = 0;
      if (rd_ack && n_ack < 4) order[n_ack++] = 1;
      #1;
      if (wr_rr) begin wr_req = 1; wr_rr = 0; end
      if (rd_rr) begin rd_req = 1; rd_rr = 0; end
      if (wr_ack) begin wr_req = 0; wr_rr = 1; end
      if (rd_ack) begin rd_req = 0; rd_rr = 1; end
    end
    chk("rr_count", n_ack, 4);
    chk("rr_order", {28'h0, order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
    wr_req = 0; rd_req = 0;
    repeat (6*P + 4) @(posedge clk);

    // reset during read data strobe
    #2 rd_req = 1; rd_addr = 8'h21; Dato = 8'h45;
    for (int r = 1; r <= 8; r++) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_pins", {24'h0, AD, CS, RD, WR, Dir_Dat, busy, rd_ack, 1'b0}, {24'h0, 8'b1111_0000});
    chk("rst_mid_rd_data", {24'h0, rd_data}, 0);
    #1 rst = 0; Dato = 8'h5C;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (rd_ack) got = 1;
      #1 if (rd_ack) rd_req = 0;
    end
    chk("rst_retry_ack", {31'h0, got}, 1);
    chk("rst_retry_data", {24'h0, rd_data}, 32'h5C);

    // inputs changed mid-transaction
    @(posedge clk); #2 rd_req = 1; rd_addr = 8'h5A; Dato = 8'h11;
    for (int r = 1; r <= 14; r++) begin
      @(posedge clk); #1;
      if (r == 4 || r == 6) chk("latched_addr", {24'h0, Dato_out}, 32'h5A);
      if (r == 12) chk("rd_data_hold", {24'h0, rd_data}, 32'h5C);
      if (r == 13) chk("capture_last", {23'h0, rd_ack, rd_data}, {23'h0, 1'b1, 8'h77});
      #1;
      if (r >= 3) rd_addr = 8'hFF;
      Dato = (r == 10) ? 8'h77 : 8'h11 + 8'(r);
      if (rd_ack) rd_req = 0;
    end

    // randomized traffic
    nw = 0; nr = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (wr_ack) nw++;
      if (rd_ack) nr++;
      #1;
      if (wr_req && (wr_ack || $urandom_range(0, 59) == 0)) wr_req = 0;
      else if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1; wr_addr = 8'($urandom); wr_data = 8'($urandom);
      end
      if (rd_req && (rd_ack || $urandom_range(0, 59) == 0)) rd_req = 0;
      else if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_req = 1; rd_addr = 8'($urandom);
      end
      if ($urandom_range(0, 39) == 0) rd_addr = 8'($urandom);
      if ($urandom_range(0, 39) == 0) wr_data = 8'($urandom);
      Dato = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 0; wr_req = 0; rd_req = 0;
    repeat (6*P + 4) @(posedge clk);
    chk("rand_progress", {30'h0, nw > 10, nr > 10}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rtc_bus_arbiter
`default_nettype wire

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Sequencer and two-port arbiter for the multiplexed address/data bus of the external RTC. It grants the bus to a writer (user time/timer programming) or a reader (display refresh of seconds, minutes, hours, date and timer registers) and runs one complete RTC bus transaction per grant. Each transaction is an address phase followed by a data phase, with registered, glitch-free strobes. It sits between the clock-control FSMs and the RTC pins, and replaces per-step decoded strobe tables with a single timed engine.

## Interface
- PHASE_CYC, 4, clock cycles per bus phase (>=1); sets strobe widths for the RTC's minimum pulse times
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_req  in  1  writer request; held high until wr_ack
- wr_addr  in  8  RTC register address for write; stable while wr_req
- wr_data  in  8  data to write; stable while wr_req
- wr_ack  out  1  one-cycle pulse: write transaction finished
- rd_req  in  1  reader request; held high until rd_ack
- rd_addr  in  8  RTC register address for read; stable while rd_req
- rd_ack  out  1  one-cycle pulse: read finished, rd_data valid
- rd_data  out  8  last byte read; held until next read completes
- busy  out  1  high whenever the FSM is not in IDLE
- Dato  in  8  RTC bus value sampled during read data phase
- Dato_out  out  8  value driven onto the RTC bus when Dir_Dat=0
- Dir_Dat  out  1  1 = RTC drives the bus (FPGA tri-states); 0 = FPGA drives
- AD, CS, RD, WR  out  1 each  RTC strobes, all active-low

## Operation
- FSM states: IDLE, ADDR_SET, ADDR_STB, ADDR_HLD, DATA_STB, RECOV.
- IDLE: all strobes high, Dir_Dat=0, Dato_out=0. If any request is pending, latch the winner (op, addr, data) and go to ADDR_SET.
- Arbitration is round-robin. With both requests pending, the port not granted last wins. With one request pending, that port wins. The last-grant register resets to "reader", so the writer wins the first tie.
- ADDR_SET (P cycles): AD=0, CS=RD=WR=1, Dato_out=addr.
- ADDR_STB (P cycles): AD=0, CS=0, WR=0, RD=1, Dato_out=addr.
- ADDR_HLD (P cycles): AD=1, CS=RD=WR=1, Dato_out=addr.
- DATA_STB (2P cycles), AD=1, CS=0:
  - Read: RD=0, WR=1, Dir_Dat=1, Dato_out=0. Dato is registered into rd_data on the last DATA_STB cycle.
  - Write: WR=0, RD=1, Dir_Dat=0, Dato_out=data.
- RECOV (P cycles): all strobes high, Dir_Dat=0, Dato_out=0. Then return to IDLE and pulse the granted port's ack for one cycle.
- Requests are sampled only in IDLE. A request dropped before grant is ignored. The latched addr/data are used for the whole transaction, so later input changes have no effect.
- A requester may re-raise req on the cycle after its ack. It then competes under normal round-robin.

## Timing
- P = PHASE_CYC. The transaction occupies 6P cycles after the grant cycle.
- Latency: req seen in IDLE at cycle 0 → ADDR_SET starts at cycle 1 → ack high at cycle 6P+1 → new grant possible at cycle 6P+1.
- All outputs are registered from state and phase counter. No combinational path from inputs to pins.
- rd_data changes only on the cycle rd_ack rises.
- Reset values: AD=CS=RD=WR=1, Dir_Dat=0, Dato_out=0, rd_data=0, wr_ack=rd_ack=0, busy=0, state=IDLE.
- Reset mid-transaction: the next cycle is IDLE with reset values on all outputs. No ack is issued for the aborted transaction, and rd_data is cleared.
- Phase counter: width $clog2(2*PHASE_CYC); loads at each phase entry and counts down to 0. With PHASE_CYC=1, every phase except DATA_STB lasts one cycle.

## Structure
- Package rtc_bus_pkg holds:
  - state enum
  - op enum (OP_RD, OP_WR)
  - port index constants (PORT_WR=0, PORT_RD=1)
  - RTC command constant RTC_CMD_XFER=8'hF0, used by the refresh FSM ahead of time/timer reads
- Sub-module rtc_phase_timer: loadable down-counter with a done flag. The arbiter FSM and output register block live in rtc_bus_arbiter.

## Test plan
- PHASE_CYC=2, rd_req with rd_addr=8'h21, Dato=8'h45 during DATA_STB:
  - AD low for cycles 1–4; CS/WR low for cycles 3–4.
  - RD low and Dir_Dat=1 for cycles 7–10.
  - rd_ack at cycle 13, rd_data=8'h45.
- PHASE_CYC=2, wr_req with addr 8'h42, data 8'h30: Dato_out=8'h42 for cycles 1–6, Dato_out=8'h30 with WR=0 for cycles 7–10, Dir_Dat never 1, wr_ack at cycle 13.
- wr_req and rd_req both high from reset: order is write, read, write, read. Each ack is exactly one cycle, and busy drops for one cycle between transactions.
- rst asserted during DATA_STB of a read: next cycle all strobes are 1, rd_data=0, no rd_ack. A new rd_req then completes normally.
- rd_addr and Dato changed mid-transaction outside the capture cycle: the bus still shows the latched address, and rd_data equals Dato at the last DATA_STB cycle only.
